merge_sort_sched: RTL and testbench

//  Shares one 32-sample merge-sort engine (4 x int8 per beat, 8 beats per block) among NREQ clients.

---
 rtl/msort_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/merge_sort_sched.sv | 149 ++++++++++++++
 tb/tb_merge_sort_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/msort_pkg.sv
// msort_pkg: shared geometry and FSM state for the merge-sort scheduler.
// One block is BEATS beats of LANES signed samples, BLOCK_N samples total.
package msort_pkg;

  localparam int SAMPLE_W = 8;
  localparam int BEATS    = 8;
  localparam int LANES    = 4;
  localparam int BLOCK_N  = 32;
  localparam int BEAT_W   = LANES * SAMPLE_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_LOAD,
    S_BLK,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first set request at or after ptr, wrapping.
// Purely combinational; hit is low when no request is pending.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] win,
  output logic [IDW-1:0]  win_id,
  output logic            hit
);

  always_comb begin
    win_id = '0;
    hit    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!hit && req[i] &&
            i == (int'(ptr) + k) % NREQ) begin
          hit    = 1'b1;
          win_id = IDW'(i);
        end
      end
    end
    win = hit ? (NREQ'(1) << win_id) : '0;
  end

endmodule

// File: rtl/merge_sort_sched.sv
// merge_sort_sched: time-shares one 32-sample sort engine among NREQ clients.
// One block in flight; results come back tagged with the owner id.
module merge_sort_sched
  import msort_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  output logic [NREQ-1:0]        gnt,
  input  logic [NREQ-1:0]        in_valid,
  input  logic [NREQ*BEAT_W-1:0] in_data,
  output logic                   in_ready,
  output logic [BEAT_W-1:0]      sort_in,
  output logic                   sort_blkin,
  input  logic [SAMPLE_W-1:0]    sort_out,
  input  logic                   sort_valid,
  output logic                   res_valid,
  output logic [SAMPLE_W-1:0]    res_data,
  output logic [IDW-1:0]         res_id,
  output logic                   res_last,
  output logic                   busy,
  output logic                   err_timeout
);

  localparam int TW = $clog2(TIMEOUT);

  state_t state, state_d;

  logic [IDW-1:0]    id;
  logic [NREQ-1:0]   own;
  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    arb_id;
  logic [NREQ-1:0]   arb_win;
  logic              arb_hit;
  logic [2:0]        beat_cnt;
  logic [5:0]        res_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic              sel_valid;
  logic [BEAT_W-1:0] sel_data;
  logic              accept;
  logic              last_beat;
  logic              res_hit;
  logic              res_done;
  logic              tmo_hit;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req    (req),
    .ptr    (ptr),
    .win    (arb_win),
    .win_id (arb_id),
    .hit    (arb_hit)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (id == IDW'(i)) begin
        sel_valid = in_valid[i];
        sel_data  = in_data[i*BEAT_W +: BEAT_W];
      end
    end
  end

  assign accept    = (state == S_LOAD) && sel_valid;
  assign last_beat = accept && (beat_cnt == 3'(BEATS-1));
  assign res_hit   = (state == S_DRAIN) && sort_valid;
  assign res_done  = res_hit && (res_cnt == 6'(BLOCK_N-1));
  // A final result landing on the last timeout cycle still completes.
  assign tmo_hit   = (state == S_DRAIN) && !res_done &&
                     (tmo_cnt == TW'(TIMEOUT-1));

  assign in_ready  = (state == S_LOAD);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  if (arb_hit) state_d = S_GRANT;
      S_GRANT: state_d = S_LOAD;
      S_LOAD:  if (last_beat) state_d = S_BLK;
      S_BLK:   state_d = S_DRAIN;
      S_DRAIN: if (res_done || tmo_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id          <= '0;
      own         <= '0;
      ptr         <= '0;
      gnt         <= '0;
      sort_in     <= '0;
      sort_blkin  <= 1'b0;
      beat_cnt    <= '0;
      res_cnt     <= '0;
      tmo_cnt     <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_id      <= '0;
      res_last    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      sort_in    <= accept ? sel_data : '0;
      sort_blkin <= last_beat;
      res_valid  <= res_hit;
      res_last   <= res_done;
      if (res_hit) begin
        res_data <= sort_out;
        res_id   <= id;
      end
      if (state == S_IDLE && arb_hit) begin
        id  <= arb_id;
        own <= arb_win;
      end
      if (state == S_GRANT) begin
        gnt      <= own;
        beat_cnt <= '0;
      end
      if (last_beat) gnt <= '0;
      if (accept) beat_cnt <= beat_cnt + 3'd1;
      if (state == S_BLK) begin
        res_cnt <= '0;
        tmo_cnt <= '0;
      end
      if (res_hit && res_cnt != 6'(BLOCK_N))
        res_cnt <= res_cnt + 6'd1;
      if (state == S_DRAIN && !res_done && !tmo_hit)
        tmo_cnt <= tmo_cnt + TW'(1);
      if (res_done || tmo_hit)
        ptr <= (id == IDW'(NREQ-1)) ? '0 : id + IDW'(1);
      if (tmo_hit) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_merge_sort_sched.sv
// tb_merge_sort_sched: randomized block traffic against a queue-based model.
// The bench plays both the clients and the sort engine.
module tb_merge_sort_sched;
  import msort_pkg::*;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 64;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        in_valid = '0;
  logic [NREQ*BEAT_W-1:0] in_data = '0;
  logic                   in_ready;
  logic [BEAT_W-1:0]      sort_in;
  logic                   sort_blkin;
  logic [SAMPLE_W-1:0]    sort_out = '0;
  logic                   sort_valid = 1'b0;
  logic                   res_valid;
  logic [SAMPLE_W-1:0]    res_data;
  logic [IDW-1:0]         res_id;
  logic                   res_last;
  logic                   busy;
  logic                   err_timeout;

  int checks = 0;
  int errors = 0;
  int exp_ptr = 0;
  bit exp_err = 1'b0;

  merge_sort_sched #(
    .NREQ    (NREQ),
    .IDW     (IDW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .gnt         (gnt),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .sort_in     (sort_in),
    .sort_blkin  (sort_blkin),
    .sort_out    (sort_out),
    .sort_valid  (sort_valid),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_id      (res_id),
    .res_last    (res_last),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 0; k < NREQ; k++)
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  // mode 0: full block, 1: engine stalls after 10 results,
  // 2: reset asserted mid-drain after 12 results
  task automatic run_block(input logic [NREQ-1:0] mask, input bit gaps,
                           input int mode, input bit fixed);
    int wid, nb, step, nres;
    bit v;
    logic [31:0] d;
    logic [NREQ-1:0] oh;
    byte samp[$];
    wid = pick(mask, exp_ptr);
    oh = NREQ'(1) << wid;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy got %0b want 0", busy);
    end
    req = mask;
    for (int k = 1; k <= 2; k++) begin
      sort_valid = 1'b1;
      sort_out = 8'($urandom);
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0) begin
        errors++;
        $display("FAIL stray_pre got res_valid=%0b want 0", res_valid);
      end
      checks++;
      if (gnt !== (k == 2 ? oh : '0)) begin
        errors++;
        $display("FAIL gnt_latency k=%0d got %b want %b", k, gnt,
                 (k == 2 ? oh : '0));
      end
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready got %0b want 1", in_ready);
    end
    req[wid] = 1'b0;
    nb = 0;
    step = 0;
    while (nb < BEATS) begin
      v = gaps ? (step % 2 == 0) : 1'b1;
      d = (fixed && nb == 0) ? 32'h08FD7F80 : $urandom;
      step++;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_valid = NREQ'($urandom);
      in_valid[wid] = v;
      in_data[wid*32 +: 32] = d;
      sort_valid = 1'($urandom);
      sort_out = 8'($urandom);
      if (v) begin
        samp.push_back(d[31:24]);
        samp.push_back(d[23:16]);
        samp.push_back(d[15:8]);
        samp.push_back(d[7:0]);
        nb++;
      end
      @(negedge clk);
      checks++;
      if (sort_in !== (v ? d : 32'h0)) begin
        errors++;
        $display("FAIL sort_in beat=%0d got %h want %h", nb, sort_in,
                 (v ? d : 32'h0));
      end
      checks++;
      if (res_valid !== 1'b0) begin
        errors++;
        $display("FAIL stray_load got res_valid=%0b want 0", res_valid);
      end
      checks++;
      if (sort_blkin !== (nb == BEATS) || gnt !== (nb == BEATS ? '0 : oh)) begin
        errors++;
        $display("FAIL blk_gnt beat=%0d got blkin=%0b gnt=%b want %0b %b",
                 nb, sort_blkin, gnt, (nb == BEATS), (nb == BEATS ? '0 : oh));
      end
    end
    in_valid = '0;
    sort_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || sort_blkin !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drain_entry got rv=%0b blkin=%0b busy=%0b want 0 0 1",
               res_valid, sort_blkin, busy);
    end
    samp.sort();
    nres = (mode == 0) ? BLOCK_N : (mode == 1) ? 10 : 12;
    for (int k = 0; k < nres; k++) begin
      sort_valid = 1'b1;
      sort_out = samp[k];
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== samp[k] ||
          res_id !== IDW'(wid) || res_last !== (k == BLOCK_N-1) ||
          busy !== (k != BLOCK_N-1)) begin
        errors++;
        $display("FAIL result k=%0d got v=%0b d=%h id=%0d last=%0b busy=%0b want 1 %h %0d %0b %0b",
                 k, res_valid, res_data, res_id, res_last, busy, samp[k],
                 wid, (k == BLOCK_N-1), (k != BLOCK_N-1));
      end
    end
    sort_valid = 1'b0;
    if (mode == 1) begin
      for (int n = nres + 2; n <= TIMEOUT + 1; n++) begin
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || res_last !== 1'b0) begin
          errors++;
          $display("FAIL tmo_quiet n=%0d got rv=%0b last=%0b want 0 0",
                   n, res_valid, res_last);
        end
        if (n >= TIMEOUT) begin
          checks++;
          if (busy !== (n == TIMEOUT) || err_timeout !== (n != TIMEOUT)) begin
            errors++;
            $display("FAIL timeout n=%0d got busy=%0b err=%0b want %0b %0b",
                     n, busy, err_timeout, (n == TIMEOUT), (n != TIMEOUT));
          end
        end
      end
      exp_err = 1'b1;
      exp_ptr = (wid + 1) % NREQ;
    end else if (mode == 2) begin
      rst = 1'b0;
      #1;
      checks++;
      if ({gnt, in_ready, sort_in, sort_blkin, res_valid, res_data, res_id,
           res_last, busy, err_timeout} !== '0) begin
        errors++;
        $display("FAIL async_reset got gnt=%b rdy=%0b si=%h blk=%0b rv=%0b rd=%h id=%0d last=%0b busy=%0b err=%0b want all 0",
                 gnt, in_ready, sort_in, sort_blkin, res_valid, res_data,
                 res_id, res_last, busy, err_timeout);
      end
      @(negedge clk);
      rst = 1'b1;
      exp_err = 1'b0;
      exp_ptr = 0;
    end else begin
      checks++;
      if (err_timeout !== exp_err) begin
        errors++;
        $display("FAIL err_sticky got %0b want %0b", err_timeout, exp_err);
      end
      exp_ptr = (wid + 1) % NREQ;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt, in_ready, sort_in, sort_blkin, res_valid, res_data, res_id,
         res_last, busy, err_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_state got gnt=%b si=%h busy=%0b err=%0b want all 0",
               gnt, sort_in, busy, err_timeout);
    end
    rst = 1'b1;
    @(negedge clk);
    run_block(4'b1111, 1'b0, 2, 1'b0);
  endtask

  task automatic test_single;
    run_block(4'b0010, 1'b0, 0, 1'b1);
  endtask

  task automatic test_round_robin;
    for (int b = 0; b < 5; b++) run_block(4'b1111, 1'b0, 0, 1'b0);
  endtask

  task automatic test_beat_gaps;
    run_block(NREQ'($urandom_range(1, 15)), 1'b1, 0, 1'b0);
    run_block(NREQ'($urandom_range(1, 15)), 1'b1, 0, 1'b0);
  endtask

  task automatic test_timeout;
    run_block(4'b1000, 1'b0, 1, 1'b0);
    run_block(NREQ'($urandom_range(1, 15)), 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back;
    for (int b = 0; b < 4; b++)
      run_block(NREQ'($urandom_range(1, 15)), 1'($urandom), 0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_beat_gaps;
    test_timeout;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
